// File: rtl/usb_rx_ctrl_if.sv
// Handshake/status bundle between the USB FS receive datapath and usb_rx_ctrl.
// slave = the controller, master = the datapath/bench that drives line events.
interface usb_rx_ctrl_if #(
  parameter int unsigned CNT_W = 7
);
  logic             d_edge;
  logic             shift_en;
  logic             byte_rcvd;
  logic             eop;
  logic [7:0]       rcv_data;
  logic             rcving;
  logic             w_enable;
  logic             r_error;
  logic [2:0]       err_code;
  logic [3:0]       pid;
  logic             pid_valid;
  logic [CNT_W-1:0] byte_cnt;
  logic             pkt_done;

  modport master (
    output d_edge, shift_en, byte_rcvd, eop, rcv_data,
    input  rcving, w_enable, r_error, err_code, pid, pid_valid, byte_cnt, pkt_done
  );

  modport slave (
    input  d_edge, shift_en, byte_rcvd, eop, rcv_data,
    output rcving, w_enable, r_error, err_code, pid, pid_valid, byte_cnt, pkt_done
  );
endinterface

// File: rtl/usb_rx_ctrl.sv
// USB 1.1 FS receive control FSM: SYNC/PID/data sequencing, error coding, FIFO write strobe.
// Optional USB_RX_MAXLEN_CHECK_EN enables the MAX_BYTES overflow check (code 4).
module usb_rx_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'h80,
  parameter int unsigned MAX_BYTES = 64,
  parameter int unsigned CNT_W     = 7
) (
  input logic          clk,
  input logic          n_rst,
  usb_rx_ctrl_if.slave bus
);
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] SYNC     = 4'd1;
  localparam logic [3:0] PID_RCV  = 4'd2;
  localparam logic [3:0] PID_CHK  = 4'd3;
  localparam logic [3:0] DATA_RCV = 4'd4;
  localparam logic [3:0] DATA_WR  = 4'd5;
  localparam logic [3:0] EOP_WAIT = 4'd6;
  localparam logic [3:0] DONE     = 4'd7;
  localparam logic [3:0] ERR      = 4'd8;
  localparam logic [3:0] ERR_EOP  = 4'd9;
  localparam logic [3:0] ERR_IDLE = 4'd10;

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  if (MAX_BYTES >= (2 ** CNT_W)) begin : g_bad_cfg
    $error("MAX_BYTES must be < 2**CNT_W");
  end

  logic [3:0]       r_state;
  logic             r_err;
  logic [2:0]       r_code;
  logic [3:0]       r_pid;
  logic             r_pid_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mid;

  logic [3:0] w_state_nxt;
  logic [2:0] w_set_code;
  logic       w_clr;
  logic       w_eos;
  logic       w_len_ovf;
  logic       w_pid_ok;

  assign w_eos    = bus.eop & bus.shift_en;
  assign w_pid_ok = (bus.rcv_data[7:4] == ~bus.rcv_data[3:0]);

`ifdef USB_RX_MAXLEN_CHECK_EN
  assign w_len_ovf = (r_state == DATA_WR) && (r_cnt == MAX_CNT);
`else
  assign w_len_ovf = 1'b0;
`endif

  // w_set_code != 0 marks an error transition carrying that cause.
  always_comb begin
    w_state_nxt = r_state;
    w_set_code  = 3'd0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE: if (bus.d_edge) begin
        w_state_nxt = SYNC;
        w_clr       = 1'b1;
      end
      SYNC: begin
        if (w_eos) begin
          w_state_nxt = ERR_EOP;
          w_set_code  = 3'd3;
        end else if (bus.byte_rcvd) begin
          if (bus.rcv_data == SYNC_BYTE) begin
            w_state_nxt = PID_RCV;
          end else begin
            w_state_nxt = ERR;
            w_set_code  = 3'd1;
          end
        end
      end
      PID_RCV: begin
        if (w_eos) begin
          w_state_nxt = ERR_EOP;
          w_set_code  = 3'd3;
        end else if (bus.byte_rcvd) begin
          w_state_nxt = PID_CHK;
        end
      end
      PID_CHK: begin
        if (w_pid_ok) begin
          w_state_nxt = DATA_RCV;
        end else begin
          w_state_nxt = ERR;
          w_set_code  = 3'd2;
        end
      end
      DATA_RCV: begin
        if (w_eos) begin
          w_state_nxt = r_mid ? ERR_EOP : EOP_WAIT;
          w_set_code  = r_mid ? 3'd3 : 3'd0;
        end else if (bus.byte_rcvd) begin
          w_state_nxt = DATA_WR;
        end
      end
      DATA_WR: begin
        if (w_len_ovf) begin
          w_state_nxt = ERR;
          w_set_code  = 3'd4;
        end else begin
          w_state_nxt = DATA_RCV;
        end
      end
      EOP_WAIT: if (bus.d_edge) w_state_nxt = DONE;
      DONE:     w_state_nxt = IDLE;
      ERR:      if (w_eos) w_state_nxt = ERR_EOP;
      ERR_EOP:  if (bus.d_edge) w_state_nxt = ERR_IDLE;
      ERR_IDLE: if (bus.d_edge) begin
        w_state_nxt = SYNC;
        w_clr       = 1'b1;
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_err       <= 1'b0;
      r_code      <= 3'd0;
      r_pid       <= 4'd0;
      r_pid_valid <= 1'b0;
      r_cnt       <= '0;
      r_mid       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_err       <= 1'b0;
        r_code      <= 3'd0;
        r_pid       <= 4'd0;
        r_pid_valid <= 1'b0;
        r_cnt       <= '0;
        r_mid       <= 1'b0;
      end else begin
        if (w_set_code != 3'd0) begin
          r_err <= 1'b1;
          if (r_code == 3'd0) r_code <= w_set_code;
        end
        if ((r_state == PID_CHK) && w_pid_ok) begin
          r_pid       <= bus.rcv_data[3:0];
          r_pid_valid <= 1'b1;
        end
        if ((r_state == DATA_WR) && !w_len_ovf && (r_cnt != CNT_SAT)) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if ((r_state == DATA_RCV) || (r_state == DATA_WR)) begin
          if (bus.byte_rcvd)     r_mid <= 1'b0;
          else if (bus.shift_en) r_mid <= 1'b1;
        end
      end
    end
  end

  assign bus.rcving    = (r_state == SYNC)     || (r_state == PID_RCV) || (r_state == PID_CHK) ||
                         (r_state == DATA_RCV) || (r_state == DATA_WR) ||
                         (r_state == EOP_WAIT) || (r_state == ERR);
  assign bus.w_enable  = (r_state == DATA_WR) && !w_len_ovf;
  assign bus.pkt_done  = (r_state == DONE);
  assign bus.r_error   = r_err;
  assign bus.err_code  = r_code;
  assign bus.pid       = r_pid;
  assign bus.pid_valid = r_pid_valid;
  assign bus.byte_cnt  = r_cnt;
endmodule
